// File: rtl/count_pkg.sv
// count_pkg: shared width, command opcodes and controller states for the counter slice
package count_pkg;
  localparam int COUNT_WIDTH = 4;
  typedef enum logic [1:0] {LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, NOP = 2'b11} cmd_op_e;
  typedef enum logic [1:0] {HOLD, LOADW, RUN} ctrl_state_e;
endpackage

// File: rtl/count_ctrl.sv
// count_ctrl: command-driven load/run controller that parks the enable-less counter on targets
module count_ctrl
  import count_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_value,
  output logic             load,
  output logic [WIDTH-1:0] data_in,
  output logic             up_down,
  input  logic [WIDTH-1:0] count,
  output logic             done,
  output logic             busy
);
  ctrl_state_e state, state_d;
  cmd_op_e op;
  logic [WIDTH-1:0] hold_q, hold_d, tgt_q, tgt_d, data_d, pre;
  logic load_d, up_d, done_d;
  assign op = cmd_op_e'(cmd_op);
  assign cmd_ready = state == HOLD;
  assign busy = state != HOLD;
  // Registered outputs lag one edge, so RUN stops when count sits one step short of target.
  assign pre = up_down ? tgt_q - WIDTH'(1) : tgt_q + WIDTH'(1);
  always_comb begin
    state_d = state;
    hold_d = hold_q;
    tgt_d = tgt_q;
    load_d = 1'b1;
    data_d = hold_q;
    up_d = up_down;
    done_d = 1'b0;
    if (state == HOLD && cmd_valid) begin
      if (op == LOAD) begin
        state_d = LOADW;
        hold_d = cmd_value;
        data_d = cmd_value;
      end else if (op != NOP) begin
        if (count == cmd_value) begin
          hold_d = cmd_value;
          data_d = cmd_value;
          done_d = 1'b1;
        end else begin
          state_d = RUN;
          tgt_d = cmd_value;
          load_d = 1'b0;
          up_d = op == UP;
        end
      end
    end else if (state == LOADW) begin
      state_d = HOLD;
      done_d = 1'b1;
    end else if (state == RUN) begin
      if (count == pre) begin
        state_d = HOLD;
        hold_d = tgt_q;
        data_d = tgt_q;
        done_d = 1'b1;
      end else begin
        load_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HOLD;
      hold_q <= '0;
      tgt_q <= '0;
      load <= 1'b1;
      data_in <= '0;
      up_down <= 1'b1;
      done <= 1'b0;
    end else begin
      state <= state_d;
      hold_q <= hold_d;
      tgt_q <= tgt_d;
      load <= load_d;
      data_in <= data_d;
      up_down <= up_d;
      done <= done_d;
    end
  end
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed commands against a trajectory model of the controller plus counter
module tb_count_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b11;
  logic [W-1:0] cmd_value = '0;
  logic load, up_down, done, busy;
  logic [W-1:0] data_in;
  logic [W-1:0] count = 4'd5;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  count_ctrl #(.WIDTH(W)) dut (
    .clock(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_value(cmd_value), .load(load), .data_in(data_in),
    .up_down(up_down), .count(count), .done(done), .busy(busy)
  );

  always @(posedge clk) count <= load ? data_in : up_down ? count + 4'd1 : count - 4'd1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted command expands into the per-cycle (count, done, busy) it must produce.
  typedef struct {logic [W-1:0] cnt; logic dn; logic bz;} ent_t;
  ent_t q[$];
  logic [W-1:0] exp_count = '0;
  logic exp_done = 1'b0;
  logic exp_busy = 1'b0;
  logic skip = 1'b1;
  logic started = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] c, n;
    ent_t e;
    if (reset) begin
      q.delete();
      exp_count = '0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      skip = 1'b1;
      started = 1'b1;
    end else begin
      skip = 1'b0;
      if (cmd_valid && !exp_busy) begin
        c = exp_count;
        if (cmd_op == 2'b00) begin
          q.push_back('{c, 1'b0, 1'b1});
          q.push_back('{cmd_value, 1'b1, 1'b0});
        end else if (cmd_op != 2'b11) begin
          n = cmd_op == 2'b01 ? cmd_value - c : c - cmd_value;
          for (int k = 0; k <= int'(n); k++)
            q.push_back('{cmd_op == 2'b01 ? c + W'(k) : c - W'(k), k == int'(n), k < int'(n)});
        end
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_count = e.cnt;
        exp_done = e.dn;
        exp_busy = e.bz;
      end else begin
        exp_done = 1'b0;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (!skip) chk("count", int'(count), int'(exp_count));
      chk("done", int'(done), int'(exp_done));
      chk("busy", int'(busy), int'(exp_busy));
      chk("cmd_ready", int'(cmd_ready), int'(!exp_busy));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] v);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      step(1);
      n++;
    end
    if (n == 100) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_value = v;
    step(1);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3));
    cmd_value = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      step(1);
      n++;
    end
    if (n == 40) chk("done_timeout", 0, 1);
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    step(5);
    chk("idle_count", int'(count), 0);
    chk("idle_load", int'(load), 1);
    chk("idle_data_in", int'(data_in), 0);
    send(2'b00, 4'd9);
    step(1);
    chk("load9_count", int'(count), 9);
    chk("load9_done", int'(done), 1);
    step(10);
    chk("load9_hold", int'(count), 9);
    send(2'b11, 4'd7);
    step(2);
    chk("nop_hold", int'(count), 9);
    send(2'b00, 4'd3);
    wait_done();
    send(2'b01, 4'd7);
    step(4);
    chk("up7_count", int'(count), 7);
    chk("up7_done", int'(done), 1);
    step(1);
    chk("up7_freeze", int'(count), 7);
    send(2'b00, 4'd14);
    wait_done();
    send(2'b01, 4'd2);
    wait_done();
    chk("wrap_up_count", int'(count), 2);
    send(2'b00, 4'd1);
    wait_done();
    send(2'b10, 4'd14);
    wait_done();
    chk("wrap_down_count", int'(count), 14);
    send(2'b00, 4'd5);
    wait_done();
    send(2'b01, 4'd5);
    chk("zero_step_done", int'(done), 1);
    send(2'b00, 4'd2);
    step(1);
    chk("b2b_load_count", int'(count), 2);
    chk("b2b_load_done", int'(done), 1);
    send(2'b00, 4'd10);
    wait_done();
    send(2'b10, 4'd0);
    for (int n = 0; n < 40 && count != 4'd7; n++) step(1);
    chk("mid_run_reached7", int'(count), 7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_reset_done", int'(done), 0);
    chk("mid_reset_busy", int'(busy), 0);
    step(1);
    chk("mid_reset_count", int'(count), 0);
    step(3);
    chk("mid_reset_hold", int'(count), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
